// File: rtl/nibbler_ram_pkg.sv
// nibbler_ram_pkg
// Shared definitions for the Nibbler RAM sequencer/arbiter:
//   RAM_ADDR_W / RAM_DATA_W : default RAM geometry (4096 x 4)
//   ram_ctl_state_t         : sequencer states
//   REQ_A / REQ_B           : requester ids used for grant/ownership
package nibbler_ram_pkg;

  localparam int RAM_ADDR_W = 12;
  localparam int RAM_DATA_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ADDR   = 3'd1,
    ST_RD_LATCH  = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_STROBE = 3'd4,
    ST_WR_HOLD   = 3'd5
  } ram_ctl_state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Combinational two-input round-robin pick.
//   elig       in  : eligible requests, indexed by requester id
//   last_grant in  : id granted most recently
//   gnt_valid  out : at least one requester eligible
//   gnt_id     out : chosen requester (only meaningful with gnt_valid)
module rr_arbiter2
  import nibbler_ram_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |elig;
    gnt_id    = REQ_A;
    if (elig[REQ_A] && elig[REQ_B]) begin
      // Tie: the requester that did not win last time goes first.
      gnt_id = (last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (elig[REQ_B]) begin
      gnt_id = REQ_B;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Sequencer and two-port round-robin arbiter for the Nibbler 4096x4
// asynchronous RAM. All RAM strobes, address, bus enable, done pulses and
// read data are registered.
//   clk, reset              : clock, synchronous active-high reset
//   req_x/we_x/addr_x/wdata_x : requester A (CPU) and B (loader) inputs
//   done_a, done_b          : one-cycle completion pulses
//   rdata                   : last read result, held until the next read
//   busy                    : transaction in progress (including done cycle)
//   address, csRam, weRam   : RAM control
//   salida                  : bidirectional RAM data bus
//
// state        | meaning
// ST_IDLE      | arbitrate, capture winner's transaction
// ST_RD_ADDR   | cs=1 we=0, RAM drives bus
// ST_RD_LATCH  | cs=1 we=0, bus sampled into rdata on exit
// ST_WR_SETUP  | we=1, data driven, cs low (address/data setup)
// ST_WR_STROBE | we=1, cs=1 write pulse
// ST_WR_HOLD   | we=1, data held, cs low (hold after pulse)
module ram_arbiter
  import nibbler_ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              done_a,
  output logic              done_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic              csRam,
  output logic              weRam,
  inout  wire  [DATA_W-1:0] salida
);

  ram_ctl_state_t    state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cs_q, cs_d;
  logic              we_ram_q, we_ram_d;
  logic              bus_oe_q, bus_oe_d;
  logic              done_a_q, done_a_d;
  logic              done_b_q, done_b_d;
  logic              busy_q, busy_d;

  logic [1:0] elig;
  logic       gnt_valid;
  logic       gnt_id;
  logic       gnt_we;

  // A requester is not re-granted in the cycle its done pulse is visible.
  assign elig[REQ_A] = req_a && !done_a_q;
  assign elig[REQ_B] = req_b && !done_b_q;

  rr_arbiter2 u_arb (
    .elig       (elig),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign gnt_we = (gnt_id == REQ_B) ? we_b : we_a;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wdata_d      = wdata_q;
    address_d    = address_q;
    rdata_d      = rdata_q;
    done_a_d     = 1'b0;
    done_b_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d      = gnt_id;
          last_grant_d = gnt_id;
          address_d    = (gnt_id == REQ_B) ? addr_b : addr_a;
          wdata_d      = (gnt_id == REQ_B) ? wdata_b : wdata_a;
          state_d      = gnt_we ? ST_WR_SETUP : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR:  state_d = ST_RD_LATCH;
      ST_RD_LATCH: begin
        rdata_d  = salida;
        done_a_d = (owner_q == REQ_A);
        done_b_d = (owner_q == REQ_B);
        state_d  = ST_IDLE;
      end
      ST_WR_SETUP: state_d = ST_WR_STROBE;
      ST_WR_STROBE: begin
        // Write completion is flagged in the hold cycle so that reads and
        // writes both report done three cycles after acceptance.
        done_a_d = (owner_q == REQ_A);
        done_b_d = (owner_q == REQ_B);
        state_d  = ST_WR_HOLD;
      end
      ST_WR_HOLD:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they register cleanly.
    cs_d     = (state_d == ST_RD_ADDR) || (state_d == ST_RD_LATCH) ||
               (state_d == ST_WR_STROBE);
    we_ram_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_STROBE) ||
               (state_d == ST_WR_HOLD);
    bus_oe_d = we_ram_d;
    busy_d   = (state_d != ST_IDLE) || done_a_d || done_b_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_A;
      last_grant_q <= REQ_B;
      wdata_q      <= '0;
      address_q    <= '0;
      rdata_q      <= '0;
      cs_q         <= 1'b0;
      we_ram_q     <= 1'b0;
      bus_oe_q     <= 1'b0;
      done_a_q     <= 1'b0;
      done_b_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wdata_q      <= wdata_d;
      address_q    <= address_d;
      rdata_q      <= rdata_d;
      cs_q         <= cs_d;
      we_ram_q     <= we_ram_d;
      bus_oe_q     <= bus_oe_d;
      done_a_q     <= done_a_d;
      done_b_q     <= done_b_d;
      busy_q       <= busy_d;
    end
  end

  assign salida  = bus_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign done_a  = done_a_q;
  assign done_b  = done_b_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign address = address_q;
  assign csRam   = cs_q;
  assign weRam   = we_ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b, address;
  logic [DW-1:0] wdata_a, wdata_b, rdata;
  logic          done_a, done_b, busy, csRam, weRam;
  wire  [DW-1:0] salida;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .done_a(done_a), .done_b(done_b), .rdata(rdata), .busy(busy),
    .address(address), .csRam(csRam), .weRam(weRam), .salida(salida)
  );

  function automatic logic [DW-1:0] init_val(int i);
    case (i)
      'h000:   return 4'h5;
      'h055:   return 4'hC;
      'h123:   return 4'h9;
      default: return 4'(i ^ (i >> 4) ^ (i >> 8));
    endcase
  endfunction

  // Asynchronous RAM: drives the bus on cs=1/we=0, commits a write when cs
  // falls while we is still high.
  logic [DW-1:0] ram [4096];
  logic          ram_ready = 1'b0;
  logic          prev_csw  = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  assign salida = (csRam && !weRam) ? ram[address] : {DW{1'bz}};

  always @(negedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (prev_csw && !csRam && weRam) begin
      ram[prev_addr] <= prev_data;
    end
    prev_csw  <= csRam && weRam;
    prev_addr <= address;
    prev_data <= salida;
  end

  // ---------------- reference model (per-cycle expectation schedule) -------
  typedef struct packed {
    logic          cs, we, drv;
    logic [DW-1:0] dval;
    logic          done_a, done_b, busy, mwr;
    logic [AW-1:0] mwa;
    logic [DW-1:0] mwd;
  } slot_t;

  typedef struct packed {
    logic          reset, req_a, we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wdata_a;
    logic          req_b, we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_b;
  } in_t;

  slot_t         sl [8];
  logic [DW-1:0] mmem [4096];
  in_t           cur;
  int            cyc = 0, busy_until = 0, pa_c = -1, pr_c = -1;
  logic [AW-1:0] pa_v, exp_addr;
  logic [DW-1:0] pr_v, exp_rdata;
  logic          last_g, check_en = 1'b0;
  int            n_checks = 0, n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare();
    slot_t s;
    s = sl[cyc % 8];
    if (pa_c == cyc) exp_addr = pa_v;
    if (pr_c == cyc) exp_rdata = pr_v;
    if (s.mwr) mmem[s.mwa] = s.mwd;
    if (check_en) begin
      chk("csRam",   32'(csRam),   32'(s.cs));
      chk("weRam",   32'(weRam),   32'(s.we));
      chk("address", 32'(address), 32'(exp_addr));
      chk("done_a",  32'(done_a),  32'(s.done_a));
      chk("done_b",  32'(done_b),  32'(s.done_b));
      chk("busy",    32'(busy),    32'(s.busy));
      chk("rdata",   32'(rdata),   32'(exp_rdata));
      if (s.drv) chk("bus_wdata", 32'(salida), 32'(s.dval));
      if (s.cs && !s.we) chk("bus_rd", 32'(salida), 32'(mmem[exp_addr]));
    end
  endtask

  task automatic model_step();
    int            i0;
    logic          ea, eb, g, wop;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    i0 = cyc % 8;
    if (cur.reset) begin
      for (int k = 0; k < 8; k++) sl[k] = '0;
      busy_until = cyc;
      last_g     = 1'b1;
      pa_c = cyc + 1; pa_v = '0;
      pr_c = cyc + 1; pr_v = '0;
      check_en = 1'b1;
    end else begin
      if (cyc > busy_until) begin
        ea = cur.req_a && !sl[i0].done_a;
        eb = cur.req_b && !sl[i0].done_b;
        if (ea || eb) begin
          g      = (ea && eb) ? ~last_g : eb;
          last_g = g;
          wop    = g ? cur.we_b : cur.we_a;
          a      = g ? cur.addr_b : cur.addr_a;
          d      = g ? cur.wdata_b : cur.wdata_a;
          pa_c = cyc + 1; pa_v = a;
          for (int k = 1; k <= 3; k++) sl[(cyc + k) % 8].busy = 1'b1;
          if (g) sl[(cyc + 3) % 8].done_b = 1'b1;
          else   sl[(cyc + 3) % 8].done_a = 1'b1;
          if (!wop) begin
            sl[(cyc + 1) % 8].cs = 1'b1;
            sl[(cyc + 2) % 8].cs = 1'b1;
            pr_c = cyc + 3; pr_v = mmem[a];
            busy_until = cyc + 2;
          end else begin
            for (int k = 1; k <= 3; k++) begin
              sl[(cyc + k) % 8].we   = 1'b1;
              sl[(cyc + k) % 8].drv  = 1'b1;
              sl[(cyc + k) % 8].dval = d;
            end
            sl[(cyc + 2) % 8].cs  = 1'b1;
            sl[(cyc + 3) % 8].mwr = 1'b1;
            sl[(cyc + 3) % 8].mwa = a;
            sl[(cyc + 3) % 8].mwd = d;
            busy_until = cyc + 3;
          end
        end
      end
      sl[i0] = '0;
    end
    cyc++;
  endtask

  // One cycle: check the current cycle, then present `cur` as its inputs.
  task automatic cycle();
    @(negedge clk);
    compare();
    reset   = cur.reset;
    req_a   = cur.req_a;  we_a = cur.we_a;  addr_a = cur.addr_a;  wdata_a = cur.wdata_a;
    req_b   = cur.req_b;  we_b = cur.we_b;  addr_b = cur.addr_b;  wdata_b = cur.wdata_b;
    model_step();
  endtask

  task automatic idle(int n);
    cur = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_a(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    cur.req_a = 1'b1; cur.we_a = we; cur.addr_a = a; cur.wdata_a = d;
  endtask

  task automatic set_b(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    cur.req_b = 1'b1; cur.we_b = we; cur.addr_b = a; cur.wdata_b = d;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mmem[i] = init_val(i);
    for (int k = 0; k < 8; k++) sl[k] = '0;
    exp_addr = '0; exp_rdata = '0; pa_v = '0; pr_v = '0; last_g = 1'b1;
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;

    cur = '0; cur.reset = 1'b1;
    cycle(); cycle();
    idle(1);
    chk("lit_rst_addr", 32'(address), 32'h0);
    chk("lit_rst_busy", 32'(busy), 32'h0);

    // A read 0x123 holding 0x9
    cur = '0; set_a(1'b0, 12'h123, 4'h0); cycle();
    cur = '0;
    cycle(); chk("lit_rd_cs1", 32'(csRam), 32'h1); chk("lit_rd_we", 32'(weRam), 32'h0);
    cycle(); chk("lit_rd_cs2", 32'(csRam), 32'h1);
    cycle(); chk("lit_rd_done", 32'(done_a), 32'h1); chk("lit_rd_data", 32'(rdata), 32'h9);
    chk("lit_rd_cs3", 32'(csRam), 32'h0);
    idle(2);

    // B write 0xA to 0xFFF, then A read it back
    cur = '0; set_b(1'b1, 12'hFFF, 4'hA); cycle();
    cur = '0;
    cycle(); chk("lit_wr_we1", 32'(weRam), 32'h1); chk("lit_wr_cs1", 32'(csRam), 32'h0);
    chk("lit_wr_bus", 32'(salida), 32'hA);
    cycle(); chk("lit_wr_cs2", 32'(csRam), 32'h1);
    cycle(); chk("lit_wr_cs3", 32'(csRam), 32'h0); chk("lit_wr_done", 32'(done_b), 32'h1);
    cycle(); chk("lit_wr_we4", 32'(weRam), 32'h0);
    cur = '0; set_a(1'b0, 12'hFFF, 4'h0); cycle();
    cur = '0; cycle(); cycle(); cycle();
    chk("lit_rbw_data", 32'(rdata), 32'hA);

    // Reset, then simultaneous requests held high: A, B, A ...
    cur = '0; cur.reset = 1'b1; cycle();
    cur = '0; set_a(1'b0, 12'h010, 4'h0); set_b(1'b0, 12'h020, 4'h0);
    for (int i = 0; i < 4; i++) cycle();
    chk("lit_tie_a_first", 32'({done_a, done_b}), 32'h2);
    cycle(); cycle(); cycle();
    chk("lit_tie_b_second", 32'({done_a, done_b}), 32'h1);
    for (int i = 0; i < 6; i++) cycle();
    idle(6);

    // A holds req across done with writes; no same-cycle reissue
    cur = '0; set_a(1'b1, 12'h0AA, 4'h6);
    for (int i = 0; i < 4; i++) cycle();
    chk("lit_hold_done", 32'(done_a), 32'h1);
    cycle(); chk("lit_hold_gap_busy", 32'(busy), 32'h0); chk("lit_hold_gap_we", 32'(weRam), 32'h0);
    cur = '0;
    cycle(); chk("lit_hold_next_we", 32'(weRam), 32'h1);
    idle(6);

    // Reset during WR_STROBE abandons the write
    cur = '0; set_a(1'b1, 12'h055, 4'h3); cycle();
    cur = '0; cycle();
    cur.reset = 1'b1; cycle();
    cur = '0; cycle();
    chk("lit_rstwr_cs", 32'(csRam), 32'h0); chk("lit_rstwr_we", 32'(weRam), 32'h0);
    chk("lit_rstwr_done", 32'(done_a), 32'h0);
    cur = '0; set_a(1'b0, 12'h055, 4'h0); cycle();
    cur = '0; cycle(); cycle(); cycle();
    chk("lit_rstwr_mem", 32'(rdata), 32'hC);
    idle(2);

    // Back-to-back reads at both ends of the address range
    cur = '0; set_a(1'b0, 12'h000, 4'h0); cycle();
    cur = '0; cycle(); chk("lit_b2b_addr0", 32'(address), 32'h000);
    cycle();
    set_b(1'b0, 12'hFFF, 4'h0); cycle();
    chk("lit_b2b_rd0", 32'(rdata), 32'h5);
    cur = '0; cycle(); chk("lit_b2b_addr1", 32'(address), 32'hFFF);
    cycle(); chk("lit_b2b_hold", 32'(rdata), 32'h5);
    cycle(); chk("lit_b2b_rd1", 32'(rdata), 32'hA); chk("lit_b2b_doneb", 32'(done_b), 32'h1);
    idle(3);

    // Randomized traffic
    cur = '0;
    for (int i = 0; i < 4000; i++) begin
      cur.reset = ($urandom_range(0, 299) == 0);
      if (cur.req_a) cur.req_a = ($urandom_range(0, 3) != 0);
      else           cur.req_a = ($urandom_range(0, 2) == 0);
      if (cur.req_b) cur.req_b = ($urandom_range(0, 3) != 0);
      else           cur.req_b = ($urandom_range(0, 2) == 0);
      cur.we_a    = 1'($urandom_range(0, 1));
      cur.we_b    = 1'($urandom_range(0, 1));
      cur.addr_a  = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 7)) : 12'($urandom);
      cur.addr_b  = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 7)) : 12'($urandom);
      cur.wdata_a = 4'($urandom);
      cur.wdata_b = 4'($urandom);
      cycle();
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
